// File: rtl/pwconv_pkg.sv
// pwconv_pkg: shared widths, output range and signed saturation for the pointwise/depthwise requant paths
package pwconv_pkg;
    localparam int DATA_W   = 8;
    localparam int FILTER_W = 8;
    localparam int ACC_W    = DATA_W + FILTER_W + 6;
    localparam int OUT_W    = 8;
    localparam int OUT_MAX  = 2 ** (OUT_W - 1) - 1;
    localparam int OUT_MIN  = -(2 ** (OUT_W - 1));

    function automatic logic signed [OUT_W-1:0] sat_s(input logic signed [ACC_W:0] v);
        return (v > OUT_MAX) ? OUT_W'(OUT_MAX) : (v < OUT_MIN) ? OUT_W'(OUT_MIN) : v[OUT_W-1:0];
    endfunction
endpackage

// File: rtl/pwconv_round_shift.sv
// pwconv_round_shift: round-half-up arithmetic right shift, one guard bit so the rounding add cannot overflow
module pwconv_round_shift
    import pwconv_pkg::*;
#(
    parameter int SHIFT_W = 5
) (
    input  logic signed [ACC_W-1:0]   i_acc,
    input  logic        [SHIFT_W-1:0] i_shift,
    output logic signed [ACC_W:0]     o_r
);
    logic signed [ACC_W:0] w_ext;
    logic signed [ACC_W:0] w_half;

    assign w_ext  = {i_acc[ACC_W-1], i_acc};
    assign w_half = (i_shift == '0) ? '0 : $signed((ACC_W+1)'(1) << (i_shift - 1'b1));
    assign o_r    = (w_ext + w_half) >>> i_shift;
endmodule

// File: rtl/pwconv_requant.sv
// pwconv_requant: 3-stage requant pipeline (register, round-shift, relu/clamp) with channel counter and sticky sat flag.
// Define PWCONV_REQUANT_RELU_EN to zero negative results before clamping.
module pwconv_requant
    import pwconv_pkg::*;
#(
    parameter int NUM_OC  = 16,
    parameter int SHIFT_W = 5,
    localparam int CH_W   = $clog2(NUM_OC)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic        [SHIFT_W-1:0] shift_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic signed [OUT_W-1:0]  act_o,
    output logic        [CH_W-1:0]   ch_o,
    output logic                     last_o,
    output logic                     sat_flag_o
);
    logic                      r_v1, r_v2, r_v3;
    logic signed [ACC_W-1:0]   r_acc1;
    logic        [SHIFT_W-1:0] r_sh1;
    logic signed [ACC_W:0]     r_r2;
    logic signed [OUT_W-1:0]   r_act3;
    logic                      r_sat3;
    logic        [CH_W-1:0]    r_ch;
    logic                      r_sat_flag;
    logic                      w_rdy1, w_rdy2, w_rdy3;
    logic signed [ACC_W:0]     w_r;
    logic signed [ACC_W:0]     w_relu;
    logic                      w_clamp;

    pwconv_round_shift #(.SHIFT_W(SHIFT_W)) u_round_shift (
        .i_acc  (r_acc1),
        .i_shift(r_sh1),
        .o_r    (w_r)
    );

    assign w_rdy3 = !r_v3 || out_ready_i;
    assign w_rdy2 = !r_v2 || w_rdy3;
    assign w_rdy1 = !r_v1 || w_rdy2;

`ifdef PWCONV_REQUANT_RELU_EN
    assign w_relu = (r_r2 < 0) ? '0 : r_r2;
`else
    assign w_relu = r_r2;
`endif
    // ReLU zeroing happens before this test, so it never counts as a clamp
    assign w_clamp = (w_relu > OUT_MAX) || (w_relu < OUT_MIN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_v3       <= 1'b0;
            r_acc1     <= '0;
            r_sh1      <= '0;
            r_r2       <= '0;
            r_act3     <= '0;
            r_sat3     <= 1'b0;
            r_ch       <= '0;
            r_sat_flag <= 1'b0;
        end else if (clr_i) begin
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_v3       <= 1'b0;
            r_ch       <= '0;
            r_sat_flag <= 1'b0;
        end else begin
            if (w_rdy1) begin
                r_v1 <= in_valid_i;
                if (in_valid_i) begin
                    r_acc1 <= acc_i;
                    r_sh1  <= shift_i;
                end
            end
            if (w_rdy2) begin
                r_v2 <= r_v1;
                if (r_v1) r_r2 <= w_r;
            end
            if (w_rdy3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_act3 <= sat_s(w_relu);
                    r_sat3 <= w_clamp;
                end
            end
            if (r_v3 && out_ready_i) begin
                r_ch <= (r_ch == CH_W'(NUM_OC - 1)) ? '0 : r_ch + 1'b1;
                if (r_sat3) r_sat_flag <= 1'b1;
            end
        end
    end

    assign in_ready_o  = w_rdy1;
    assign out_valid_o = r_v3;
    assign act_o       = r_act3;
    assign ch_o        = r_ch;
    assign last_o      = (r_ch == CH_W'(NUM_OC - 1));
    assign sat_flag_o  = r_sat_flag;
endmodule
